// File: rtl/downstream_pkt_tx.sv
// Framed packet transmitter for one switch input port: buffers payload bytes, then
// sends dest, length, payload and an XOR parity byte under ready/valid backpressure.
module downstream_pkt_tx #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int IFG     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W-1:0]            dest_i,
    input  logic                         start_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic                         frame_o,
    output logic [DATA_W-1:0]            data_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [$clog2(MAX_LEN+1)-1:0] count_o
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, DEST, LEN, PAYLOAD, PARITY, GAP} state_t;

    state_t            state;
    logic [DATA_W-1:0] buf_mem [MAX_LEN];
    logic [CW-1:0]     len;
    logic [CW-1:0]     ptr;
    logic [CW-1:0]     nxt;
    logic [DATA_W-1:0] par;
    logic [GW-1:0]     gap_cnt;
    logic              xfer;
    logic              wr_ok;
    logic              start_ok;

    assign valid_o  = (state == DEST) || (state == LEN) || (state == PAYLOAD) || (state == PARITY);
    assign frame_o  = valid_o;
    assign busy_o   = (state != IDLE);
    assign xfer     = valid_o && ready_i;
    assign nxt      = ptr + CW'(1);
    assign wr_ok    = wr_en && (state == IDLE) && (count_o < FULL);
    // start sees the count from before any same-cycle write
    assign start_ok = start_i && (state == IDLE) && (count_o != '0);

    // Payload storage needs no reset: count_o alone defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            buf_mem[count_o[PW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            data_o  <= '0;
            count_o <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            len     <= '0;
            ptr     <= '0;
            par     <= '0;
            gap_cnt <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= (wr_en && !wr_ok) || (start_i && !start_ok);
            if (wr_ok) begin
                count_o <= count_o + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= DEST;
                        data_o <= dest_i;
                        len    <= count_o;
                        par    <= '0;
                    end
                end
                DEST: begin
                    if (xfer) begin
                        state  <= LEN;
                        par    <= par ^ data_o;
                        data_o <= DATA_W'(len);
                    end
                end
                LEN: begin
                    if (xfer) begin
                        state  <= PAYLOAD;
                        ptr    <= '0;
                        par    <= par ^ data_o;
                        data_o <= buf_mem[0];
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        par <= par ^ data_o;
                        if (ptr == len - CW'(1)) begin
                            state  <= PARITY;
                            data_o <= par ^ data_o;
                        end else begin
                            ptr    <= nxt;
                            data_o <= buf_mem[nxt[PW-1:0]];
                        end
                    end
                end
                PARITY: begin
                    if (xfer) begin
                        done_o  <= 1'b1;
                        count_o <= '0;
                        data_o  <= '0;
                        if (IFG == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GW'(IFG - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
